// File: rtl/qam_bit_packer_pkg.sv
// ofdm_pkg: shared QAM packer types and the bits-per-symbol helper
package ofdm_pkg;
  typedef enum logic [1:0] {QAM_BPSK, QAM_QPSK, QAM_16QAM, QAM_64QAM} qam_type_e;
  typedef enum logic {ACCUM, FLUSH_PEND} packer_state_e;
  function automatic int bits_per_symbol(qam_type_e t);
    return t == QAM_BPSK ? 1 : t == QAM_QPSK ? 2 : t == QAM_16QAM ? 4 : 6;
  endfunction
endpackage

// File: rtl/packer_fifo.sv
// packer_fifo: show-ahead sync FIFO with same-cycle push/pop; push while full is accepted only alongside a pop
module packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr_en);
      rd_ptr <= rd_ptr + (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/qam_bit_packer.sv
// qam_bit_packer: packs demapped QAM symbols LSB-first into bytes behind an overflow-flagging FIFO.
// Optional QAM_PACKER_STATS_EN adds sym_count/byte_count outputs.
module qam_bit_packer
  import ofdm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] qam_type,
  input  logic [5:0] qam_symbol,
  input  logic       qam_symbol_valid,
  input  logic       flush,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       overflow,
  input  logic       overflow_clr
`ifdef QAM_PACKER_STATS_EN
  ,
  output logic [31:0] sym_count,
  output logic [31:0] byte_count
`endif
);
  packer_state_e state;
  logic [12:0] acc, acc_sum;
  logic [3:0] acc_cnt, cnt_sum, bps;
  logic [5:0] sym;
  logic flush_now, push, pop, full, empty;
  assign bps = 4'(bits_per_symbol(qam_type_e'(qam_type)));
  assign sym = qam_symbol & ~(6'h3f << bps);
  assign acc_sum = acc | (qam_symbol_valid ? 13'(sym) << acc_cnt : 13'd0);
  assign cnt_sum = acc_cnt + (qam_symbol_valid ? bps : 4'd0);
  // a pending flush also swallows this cycle's symbol when the total still fits one byte
  assign flush_now = state == FLUSH_PEND || (flush && !qam_symbol_valid);
  assign push = cnt_sum >= 4'd8 || (flush_now && cnt_sum != 4'd0);
  assign pop = byte_valid && byte_ready;
  assign byte_valid = !empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ACCUM;
      acc <= '0;
      acc_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state == ACCUM && flush && qam_symbol_valid ? FLUSH_PEND : ACCUM;
      acc <= push ? acc_sum >> 8 : acc_sum;
      acc_cnt <= push ? (cnt_sum >= 4'd8 ? cnt_sum - 4'd8 : 4'd0) : cnt_sum;
      overflow <= (push && full && !pop) || (overflow && !overflow_clr);
    end
  packer_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .reset,
    .push,
    .din(acc_sum[7:0]),
    .pop,
    .dout(byte_data),
    .full,
    .empty
  );
`ifdef QAM_PACKER_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sym_count <= '0;
      byte_count <= '0;
    end else begin
      sym_count <= sym_count + 32'(qam_symbol_valid);
      byte_count <= byte_count + 32'(pop);
    end
`endif
endmodule

// File: tb/tb_qam_bit_packer.sv
// tb_qam_bit_packer: directed and randomized checks against a bit-queue reference model
module tb_qam_bit_packer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0;
  logic [1:0] qam_type = 0;
  logic [5:0] qam_symbol = 0;
  logic qam_symbol_valid = 0, flush = 0, byte_ready = 0, overflow_clr = 0;
  logic [7:0] byte_data;
  logic byte_valid, overflow;
`ifdef QAM_PACKER_STATS_EN
  logic [31:0] sym_count, byte_count;
`endif
  int n_vec = 0, n_err = 0;
  bit mq[$];
  logic [7:0] fq[$];
  bit m_pend, m_ovf;

  always #5 clk = ~clk;

  qam_bit_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .qam_type(qam_type), .qam_symbol(qam_symbol),
    .qam_symbol_valid(qam_symbol_valid), .flush(flush), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .overflow(overflow),
    .overflow_clr(overflow_clr)
`ifdef QAM_PACKER_STATS_EN
    , .sym_count(sym_count), .byte_count(byte_count)
`endif
  );

  task automatic model_reset();
    mq.delete();
    fq.delete();
    m_pend = 0;
    m_ovf = 0;
  endtask

  // applies one cycle of inputs and advances the reference model to the post-edge state
  task automatic drive(input bit v, input logic [1:0] t, input logic [5:0] s,
                       input bit f, input bit r, input bit c);
    bit pop, drop;
    int bps, take;
    logic [7:0] b;
    qam_symbol_valid = v; qam_type = t; qam_symbol = s;
    flush = f; byte_ready = r; overflow_clr = c;
    pop = fq.size() > 0 && r;
    bps = (t == 3) ? 6 : (1 << t);
    if (v) for (int i = 0; i < bps; i++) mq.push_back(s[i]);
    take = m_pend ? (mq.size() > 8 ? 8 : mq.size()) :
           mq.size() >= 8 ? 8 : (f && !v) ? mq.size() : 0;
    b = 0;
    drop = 0;
    for (int i = 0; i < take; i++) b[i] = mq.pop_front();
    if (pop) void'(fq.pop_front());
    if (take > 0) begin
      if (fq.size() < DEPTH) fq.push_back(b);
      else drop = 1;
    end
    m_ovf = drop || (m_ovf && !c);
    m_pend = !m_pend && f && v;
    @(posedge clk);
    @(negedge clk);
    qam_symbol_valid = 0; flush = 0; overflow_clr = 0;
  endtask

  task automatic idle(input bit r);
    drive(0, 2'd0, 6'd0, 0, r, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", byte_valid); end
    n_vec++; if (byte_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %02h want 00", byte_data); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_qpsk();
    drive(1, 2'd1, 6'h01, 0, 1, 0);
    drive(1, 2'd1, 6'h02, 0, 1, 0);
    drive(1, 2'd1, 6'h03, 0, 1, 0);
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL qpsk_early got %0b want 0", byte_valid); end
    drive(1, 2'd1, 6'h00, 0, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || fq.size() != 1) begin n_err++; $display("FAIL qpsk_valid got %0b want 1", byte_valid); end
    n_vec++; if (byte_data !== 8'h39 || fq[0] !== 8'h39) begin n_err++; $display("FAIL qpsk_data got %02h want 39", byte_data); end
    idle(1);
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL qpsk_pop got %0b want 0", byte_valid); end
  endtask

  task automatic test_64qam_flush();
    drive(1, 2'd3, 6'h3F, 0, 1, 0);
    drive(1, 2'd3, 6'h00, 0, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h3F) begin n_err++; $display("FAIL q64_byte got %0b/%02h want 1/3f", byte_valid, byte_data); end
    drive(0, 2'd0, 6'h00, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h00) begin n_err++; $display("FAIL q64_pad got %0b/%02h want 1/00", byte_valid, byte_data); end
    idle(1);
    drive(0, 2'd0, 6'h00, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL q64_empty_flush got %0b want 0", byte_valid); end
  endtask

  task automatic test_bpsk_flush();
    repeat (3) drive(1, 2'd0, 6'h01, 0, 1, 0);
    drive(0, 2'd0, 6'h00, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h07) begin n_err++; $display("FAIL bpsk_flush got %0b/%02h want 1/07", byte_valid, byte_data); end
    idle(1);
    drive(0, 2'd0, 6'h00, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL bpsk_reflush got %0b want 0", byte_valid); end
  endtask

  task automatic test_overflow();
    repeat (40) drive(1, 2'd0, 6'h01, 0, 0, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF) begin n_err++; $display("FAIL ovf_head got %0b/%02h want 1/ff", byte_valid, byte_data); end
    n_vec++; if (overflow !== 1'b1 || !m_ovf) begin n_err++; $display("FAIL ovf_set got %0b want 1", overflow); end
    drive(0, 2'd0, 6'h00, 0, 0, 1);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %0b want 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF) begin n_err++; $display("FAIL ovf_drain%0d got %0b/%02h want 1/ff", i, byte_valid, byte_data); end
      idle(1);
    end
    n_vec++; if (byte_valid !== 1'b0 || fq.size() != 0) begin n_err++; $display("FAIL ovf_dropped got %0b want 0", byte_valid); end
  endtask

  task automatic test_mixed();
    drive(1, 2'd2, 6'h3A, 0, 1, 0);
    drive(1, 2'd0, 6'h21, 0, 1, 0);
    drive(1, 2'd1, 6'h2F, 0, 1, 0);
    drive(1, 2'd0, 6'h3E, 0, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h7A) begin n_err++; $display("FAIL mixed_byte got %0b/%02h want 1/7a", byte_valid, byte_data); end
    drive(1, 2'd1, 6'h02, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL mixed_pend got %0b want 0", byte_valid); end
    idle(1);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h02) begin n_err++; $display("FAIL mixed_pad got %0b/%02h want 1/02", byte_valid, byte_data); end
    idle(1);
    repeat (5) drive(1, 2'd0, 6'h01, 0, 1, 0);
    drive(1, 2'd3, 6'h3F, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF) begin n_err++; $display("FAIL pend_full got %0b/%02h want 1/ff", byte_valid, byte_data); end
    drive(1, 2'd3, 6'h15, 0, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'hAF || fq[0] !== 8'hAF) begin n_err++; $display("FAIL pend_excess got %0b/%02h want 1/af", byte_valid, byte_data); end
    idle(1);
    drive(0, 2'd0, 6'h00, 1, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h00) begin n_err++; $display("FAIL pend_remnant got %0b/%02h want 1/00", byte_valid, byte_data); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    repeat (21) drive(1, 2'd0, 6'h01, 0, 0, 0);
    n_vec++; if (byte_valid !== 1'b1 || fq.size() != 2) begin n_err++; $display("FAIL rmid_queued got %0b want 1", byte_valid); end
    reset = 0;
    model_reset();
    #1;
    n_vec++; if (byte_valid !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL rmid_async got %0b/%0b want 0/0", byte_valid, overflow); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    drive(1, 2'd1, 6'h01, 0, 1, 0);
    drive(1, 2'd1, 6'h02, 0, 1, 0);
    drive(1, 2'd1, 6'h03, 0, 1, 0);
    drive(1, 2'd1, 6'h00, 0, 1, 0);
    n_vec++; if (byte_valid !== 1'b1 || byte_data !== 8'h39) begin n_err++; $display("FAIL rmid_fresh got %0b/%02h want 1/39", byte_valid, byte_data); end
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit r;
      r = (i / 100) % 2 == 0 ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      drive($urandom_range(0, 9) < 7, 2'($urandom), 6'($urandom), $urandom_range(0, 9) == 0,
            r, $urandom_range(0, 19) == 0);
      n_vec++; if (byte_valid !== (fq.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d got %0b want %0b", i, byte_valid, fq.size() > 0); end
      if (fq.size() > 0) begin
        n_vec++; if (byte_data !== fq[0]) begin n_err++; $display("FAIL rnd_data@%0d got %02h want %02h", i, byte_data, fq[0]); end
      end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d got %0b want %0b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_64qam_flush();
    test_bpsk_flush();
    test_overflow();
    test_mixed();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
